spi_word_rx: RTL and testbench
==============================

// Module: spi_word_rx
// PURPOSE
//  SPI mode-0 slave deserialiser upstream of the angle-setpoint stage. Receives 16-bit MSB-first
//  frames from the host, presents each completed word on byte_data_received with a 1-cycle
//  byte_received strobe. Bits [15:8] carry the register code, [7:0] the payload. Echoes the last
//  accepted word on MISO during the next frame and counts framing errors.
// PARAMETERS
//  WORD_W       16  bits per SPI word; output width
//  SYNC_STAGES  2   flip-flop depth of input synchronisers (min 2)
//  ERR_W        8   width of saturating framing-error counter
// PORTS
//  clk50M             in   1       system clock, 50 MHz
//  rst                in   1       asynchronous reset, active-high
//  spi_sclk           in   1       SPI clock from host, asynchronous to clk50M
//  spi_cs_n           in   1       SPI chip select, active-low, asynchronous
//  spi_mosi           in   1       SPI data host->slave
//  spi_miso           out  1       SPI data slave->host
//  byte_data_received out  WORD_W  last completed word, held until next completion
//  byte_received      out  1       1-cycle strobe: byte_data_received updated this cycle
//  frame_err          out  1       1-cycle strobe: cs_n rose mid-word
//  err_count          out  ERR_W   saturating count of frame_err events
// BEHAVIOUR
//  - Reset (async, active-high): all outputs 0; state IDLE; shift regs, bit_cnt, echo reg 0.
//  - sclk, cs_n, mosi each pass SYNC_STAGES FFs; sclk gets rise/fall detect, cs_n gets rise/fall
//    detect on synchronised copies. All logic is clk50M only; no logic on spi_sclk.
//  - Supported sclk <= clk50M/8 (6.25 MHz); high and low phases >= 4 clk50M cycles each.
//  - FSM IDLE: cs_n(sync) high; sclk edges ignored; spi_miso = 0.
//      cs_n fall -> SHIFT; bit_cnt=0; tx_sr <= echo_reg; spi_miso <= echo_reg[WORD_W-1].
//  - FSM SHIFT:
//      sclk rise: rx_sr <= {rx_sr[WORD_W-2:0], mosi_sync}; bit_cnt++.
//        If bit_cnt was WORD_W-1: next cycle byte_data_received <= completed word,
//        byte_received=1, echo_reg <= same word, bit_cnt <= 0; stay SHIFT (back-to-back words
//        within one cs_n frame allowed; tx_sr reloaded from the new echo_reg value).
//      sclk fall: tx_sr shifts left, spi_miso <= next bit (MSB first).
//      cs_n rise: -> IDLE. If bit_cnt != 0: frame_err=1 one cycle, err_count +1 saturating at
//        2^ERR_W-1, partial rx_sr discarded, byte_data_received unchanged.
//  - Latency: byte_received asserts SYNC_STAGES+2 clk50M cycles after the pad-level 16th
//    sclk rising edge; byte_received never asserts on two consecutive cycles.
//  - Simultaneous: 16th sclk rise and cs_n rise detected same cycle -> word accepted first,
//    no frame_err. cs_n fall and sclk rise same cycle -> sclk edge ignored.
//  - cs_n high for a full frame with zero bits clocked: no strobe, no error.
//  - Reset mid-frame: partial word lost, no strobe or error; next frame starts clean.
//  - Consumer latches on byte_received only; word holds stable otherwise.
// STRUCTURE
//  - spi_defs.vh: WORD_W default, state encodings (ST_IDLE, ST_SHIFT), register codes
//    shared with setpoint logic (e.g. REG_ANGLE = 8'h04).
//  - Sub-module sync_edge (SYNC_STAGES FF chain + rise/fall pulses), instantiated for sclk
//    and cs_n; mosi uses plain synchroniser output of a third sync_edge.
//  - Top: FSM, bit_cnt, rx_sr, tx_sr, echo_reg, output and error registers.
// TESTING
//  1. Reset, cs_n low, send 16'h04A5 at sclk=5 MHz -> one byte_received pulse,
//     byte_data_received=16'h04A5, frame_err=0.
//  2. Two words 16'h0410, 16'h04FF in one cs_n frame -> two strobes, values in order; MISO
//     during second word shifts out 16'h0410.
//  3. cs_n rises after 9 bits -> frame_err pulse, err_count=1, byte_data_received unchanged.
//  4. 2^ERR_W+3 truncated frames -> err_count saturates at 8'hFF.
//  5. sclk toggling 20 times with cs_n high -> no strobe, no error, spi_miso=0.
//  6. Assert rst after 12 bits of 16'h0433 -> outputs 0; following full frame 16'h0401
//     -> single strobe with 16'h0401, err_count=0.

Source files
------------

// File: rtl/spi_word_rx_pkg.sv
// Constants shared between the SPI word receiver and the angle-setpoint logic downstream.
package spi_word_rx_pkg;

    localparam int WORD_W_DEF = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [7:0] REG_ANGLE = 8'h04;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] payload;
    } spi_word_t;

    function automatic logic [7:0] reg_code(input logic [15:0] word);
        return word[15:8];
    endfunction

endpackage

// File: rtl/spi_word_rx_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pad input, with rise/fall pulses
// taken from the synchronised copy.
module spi_word_rx_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_q    = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_prev;
    assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave word deserialiser: clk50M-domain sampling of sclk/cs_n/mosi,
// echo of the last accepted word on MISO, saturating framing-error count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | cs_n high; sclk edges ignored; MISO driven low
//   ST_SHIFT | frame active; sample MOSI on sclk rise, drive MISO on fall
module spi_word_rx
    import spi_word_rx_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic              clk50M,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [WORD_W-1:0] byte_data_received,
    output logic              byte_received,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_count
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
    logic w_sclk_q_unused, w_cs_q_unused;
    logic [1:0] w_mosi_edge_unused;

    spi_word_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(clk50M), .i_rst(rst), .i_d(spi_sclk),
        .o_q(w_sclk_q_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_word_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(clk50M), .i_rst(rst), .i_d(spi_cs_n),
        .o_q(w_cs_q_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_word_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(clk50M), .i_rst(rst), .i_d(spi_mosi),
        .o_q(w_mosi), .o_rise(w_mosi_edge_unused[0]), .o_fall(w_mosi_edge_unused[1])
    );

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_rx_sr, r_tx_sr, r_echo, r_word;
    logic              r_word_done, r_strobe, r_frame_err, r_miso;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_last_rise;
    logic [WORD_W-1:0] w_echo_next, w_tx_cur;

    assign w_last_rise = (r_state == ST_SHIFT) && w_sclk_rise && (r_bit_cnt == LAST_BIT);

    // A word completed last cycle takes effect now, so forward it to anything reading echo/tx.
    assign w_echo_next = r_word_done ? r_rx_sr : r_echo;
    assign w_tx_cur    = r_word_done ? r_rx_sr : r_tx_sr;

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_echo      <= '0;
            r_word      <= '0;
            r_word_done <= 1'b0;
            r_strobe    <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
            r_miso      <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            r_strobe    <= 1'b0;
            r_frame_err <= 1'b0;
            r_echo      <= w_echo_next;
            r_tx_sr     <= w_tx_cur;
            if (r_word_done) begin
                r_word   <= r_rx_sr;
                r_strobe <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_tx_sr   <= w_echo_next << 1;
                        r_miso    <= w_echo_next[WORD_W-1];
                    end
                end
                default: begin
                    if (w_sclk_rise) begin
                        r_rx_sr <= {r_rx_sr[WORD_W-2:0], w_mosi};
                        if (w_last_rise) begin
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_sclk_fall) begin
                        r_miso  <= w_tx_cur[WORD_W-1];
                        r_tx_sr <= w_tx_cur << 1;
                    end
                    // A 16th rise landing with cs_n rise still completes the word.
                    if (w_cs_rise) begin
                        r_state   <= ST_IDLE;
                        r_miso    <= 1'b0;
                        r_bit_cnt <= '0;
                        if ((r_bit_cnt != '0) && !w_last_rise) begin
                            r_frame_err <= 1'b1;
                            r_rx_sr     <= '0;
                            if (r_err_cnt != ERR_MAX) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign spi_miso           = r_miso;
    assign byte_data_received = r_word;
    assign byte_received      = r_strobe;
    assign frame_err          = r_frame_err;
    assign err_count          = r_err_cnt;

endmodule

// File: tb/tb_spi_word_rx.sv
// Bench for spi_word_rx: host-side SPI driver, expected-word queue, strobe monitor.
module tb_spi_word_rx;
    import spi_word_rx_pkg::*;

    localparam int SYNC = 2;

    logic        clk50M   = 1'b0;
    logic        rst      = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] byte_data_received;
    logic        byte_received;
    logic        frame_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobes = 0;
    int n_ferr = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int exp_errs = 0;
    int exp_ferr = 0;
    logic prev_strobe = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_echo = 16'h0000;

    spi_word_rx #(.WORD_W(16), .SYNC_STAGES(SYNC), .ERR_W(8)) dut (
        .clk50M(clk50M),
        .rst(rst),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .byte_data_received(byte_data_received),
        .byte_received(byte_received),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    always #10 clk50M = ~clk50M;

    always @(posedge clk50M) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk50M) begin
        if (byte_received) begin
            n_strobes++;
            if (prev_strobe) check_val("strobe_gap", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                check_val("rx_word", {16'h0, byte_data_received}, {16'h0, exp_q.pop_front()});
                check_val("latency", cyc - last_rise_cyc, SYNC + 2);
            end
        end
        if (frame_err) n_ferr++;
        prev_strobe = byte_received;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk50M);
        #5;
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clks(6);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        wait_clks(8);
    endtask

    // Host side: MOSI set during sclk low, MISO captured at each sclk rise.
    task automatic send_bits(input logic [15:0] word, input int nbits, input bit cs_at_last);
        logic [15:0] cap;
        cap = 16'h0000;
        if (nbits == 16) exp_q.push_back(word);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = word[15-i];
            wait_clks(5);
            spi_sclk = 1'b1;
            cap[15-i] = spi_miso;
            if (i == nbits - 1) begin
                last_rise_cyc = cyc;
                if (cs_at_last) spi_cs_n = 1'b1;
            end
            wait_clks(5);
            spi_sclk = 1'b0;
        end
        if (nbits == 16) begin
            check_val("miso_echo", {16'h0, cap}, {16'h0, exp_echo});
            exp_echo = word;
        end
    endtask

    task automatic note_err();
        exp_ferr++;
        if (exp_errs < 255) exp_errs++;
    endtask

    initial begin
        wait_clks(3);
        check_val("rst_word", {16'h0, byte_data_received}, 32'h0);
        check_val("rst_strobe", {31'h0, byte_received}, 32'h0);
        check_val("rst_ferr", {31'h0, frame_err}, 32'h0);
        check_val("rst_errcnt", {24'h0, err_count}, 32'h0);
        check_val("rst_miso", {31'h0, spi_miso}, 32'h0);
        rst = 1'b0;
        wait_clks(4);

        cs_low();
        send_bits(16'h04A5, 16, 1'b0);
        cs_high();
        check_val("t1_word", {16'h0, byte_data_received}, 32'h04A5);
        check_val("t1_code", {24'h0, reg_code(byte_data_received)}, {24'h0, REG_ANGLE});
        check_val("t1_strobes", n_strobes, 1);
        check_val("t1_ferr", n_ferr, 0);
        check_val("t1_miso_idle", {31'h0, spi_miso}, 32'h0);

        cs_low();
        send_bits(16'h0410, 16, 1'b0);
        send_bits(16'h04FF, 16, 1'b0);
        cs_high();
        check_val("t2_word", {16'h0, byte_data_received}, 32'h04FF);
        check_val("t2_strobes", n_strobes, 3);
        check_val("t2_ferr", n_ferr, 0);

        cs_low();
        send_bits(16'h1234, 9, 1'b0);
        cs_high();
        note_err();
        check_val("t3_ferr", n_ferr, exp_ferr);
        check_val("t3_errcnt", {24'h0, err_count}, exp_errs);
        check_val("t3_word", {16'h0, byte_data_received}, 32'h04FF);
        check_val("t3_strobes", n_strobes, 3);

        for (int f = 0; f < 259; f++) begin
            cs_low();
            send_bits(16'h5555, 3, 1'b0);
            cs_high();
            note_err();
        end
        check_val("t4_errcnt", {24'h0, err_count}, exp_errs);
        check_val("t4_errcnt_sat", {24'h0, err_count}, 32'hFF);
        check_val("t4_ferr", n_ferr, exp_ferr);
        check_val("t4_word", {16'h0, byte_data_received}, 32'h04FF);

        for (int t = 0; t < 20; t++) begin
            spi_mosi = t[0];
            wait_clks(5);
            spi_sclk = 1'b1;
            check_val("t5_miso", {31'h0, spi_miso}, 32'h0);
            wait_clks(5);
            spi_sclk = 1'b0;
        end
        wait_clks(8);
        check_val("t5_strobes", n_strobes, 3);
        check_val("t5_ferr", n_ferr, exp_ferr);

        cs_low();
        send_bits(16'h04C3, 16, 1'b1);
        cs_high();
        check_val("t7_word", {16'h0, byte_data_received}, 32'h04C3);
        check_val("t7_strobes", n_strobes, 4);
        check_val("t7_ferr", n_ferr, exp_ferr);

        cs_low();
        send_bits(16'h0433, 12, 1'b0);
        rst = 1'b1;
        wait_clks(2);
        check_val("t6_rst_word", {16'h0, byte_data_received}, 32'h0);
        check_val("t6_rst_errcnt", {24'h0, err_count}, 32'h0);
        check_val("t6_rst_miso", {31'h0, spi_miso}, 32'h0);
        check_val("t6_rst_strobe", {31'h0, byte_received}, 32'h0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        exp_echo = 16'h0000;
        wait_clks(4);
        cs_low();
        send_bits(16'h0401, 16, 1'b0);
        cs_high();
        check_val("t6_word", {16'h0, byte_data_received}, 32'h0401);
        check_val("t6_strobes", n_strobes, 5);
        check_val("t6_errcnt", {24'h0, err_count}, 32'h0);
        check_val("t6_ferr", n_ferr, exp_ferr);
        check_val("t6_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
